// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Holds the state encoding, the bus widths and the forced-completion data word.
package mem_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [DATA_W-1:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } bus_req_t;

    // One-hot owner derived from the arbiter state; 00 while idle.
    function automatic logic [1:0] grant_of(input state_t st);
        logic [1:0] g;
        g = 2'b00;
        case (st)
            ST_GNT0: g = 2'b01;
            ST_GNT1: g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way winner select for the memory bus arbiter.
// RR != 0 alternates on contention using the last-grant pointer; RR == 0 favours m0.
module rr_pick2 #(
    parameter int RR = 1
) (
    input  logic v0,
    input  logic v1,
    input  logic last_m1,
    output logic pick_any,
    output logic pick_m1
);

    always_comb begin
        pick_any = v0 | v1;
        if (RR != 0) begin
            // On contention the master that did not own the bus last wins.
            pick_m1 = v1 & (~v0 | ~last_m1);
        end else begin
            pick_m1 = v1 & ~v0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the picorv32 valid/ready bus with registered slave request.
// Optional forced completion on a stuck slave is enabled by MEM_BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int RR      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_i,

    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              s_valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,

    output logic [1:0]        grant,
    output logic              busy
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("mem_bus_arbiter: TIMEOUT must lie in 1..255");
    end

    state_t   state;
    state_t   state_nxt;
    logic     last_m1;
    logic     last_m1_nxt;
    bus_req_t s_req;
    logic     load;
    logic     pick_any;
    logic     pick_m1;
    logic     done;
    logic     forced;

    rr_pick2 #(
        .RR(RR)
    ) u_pick (
        .v0       (m0_valid),
        .v1       (m1_valid),
        .last_m1  (last_m1),
        .pick_any (pick_any),
        .pick_m1  (pick_m1)
    );

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    logic [7:0] to_cnt;

    // Forced completion lands on the TIMEOUT-th grant cycle; a real s_ready wins.
    assign forced = (state != ST_IDLE) && !s_ready && (to_cnt == 8'(TIMEOUT - 1));
    assign err    = forced;

    always_ff @(posedge clk) begin
        if (rst_i || load) begin
            to_cnt <= '0;
        end else if (state != ST_IDLE && !s_ready) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    assign forced = 1'b0;
`endif

    assign done = s_ready | forced;

    always_comb begin
        state_nxt   = state;
        last_m1_nxt = last_m1;
        load        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    load      = 1'b1;
                    state_nxt = pick_m1 ? ST_GNT1 : ST_GNT0;
                end
            end
            ST_GNT0: begin
                if (done) begin
                    state_nxt   = ST_IDLE;
                    last_m1_nxt = 1'b0;
                end
            end
            ST_GNT1: begin
                if (done) begin
                    state_nxt   = ST_IDLE;
                    last_m1_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            last_m1 <= 1'b1;
            s_valid <= 1'b0;
            s_req   <= '0;
        end else begin
            state   <= state_nxt;
            last_m1 <= last_m1_nxt;
            if (load) begin
                s_valid <= 1'b1;
                s_req   <= pick_m1 ? bus_req_t'{m1_addr, m1_wdata, m1_wstrb}
                                   : bus_req_t'{m0_addr, m0_wdata, m0_wstrb};
            end else if (state != ST_IDLE && done) begin
                s_valid <= 1'b0;
            end
        end
    end

    assign s_addr  = s_req.addr;
    assign s_wdata = s_req.wdata;
    assign s_wstrb = s_req.wstrb;

    assign grant = grant_of(state);
    assign busy  = |grant;

    logic [DATA_W-1:0] ret_data;
    assign ret_data = forced ? BUS_ERR_DATA : s_rdata;

    assign m0_ready = grant[0] & done;
    assign m1_ready = grant[1] & done;
    assign m0_rdata = grant[0] ? ret_data : '0;
    assign m1_rdata = grant[1] ? ret_data : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: one round-robin and one fixed-priority instance.
// Build with MEM_BUS_ARB_TIMEOUT_EN to also exercise forced completion (TIMEOUT = 8).
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int TO = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          dly;
        bit          wiggle;
        bit          drop;
    } req_t;

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          cycles;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst     [2];
    logic        m_valid [2][2];
    logic [31:0] m_addr  [2][2];
    logic [31:0] m_wdata [2][2];
    logic [3:0]  m_wstrb [2][2];
    logic        m_ready [2][2];
    logic [31:0] m_rdata [2][2];
    logic        s_valid [2];
    logic [31:0] s_addr  [2];
    logic [31:0] s_wdata [2];
    logic [3:0]  s_wstrb [2];
    logic        s_ready [2];
    logic [31:0] s_rdata [2];
    logic [1:0]  grant   [2];
    logic        busy    [2];
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    logic        err     [2];
`endif

    int lat      [2];
    int poke_req [2];

    int n_chk  = 0;
    int n_fail = 0;

    req_t rq00[$], rq01[$], rq10[$], rq11[$];
    exp_t exp_q0[$], exp_q1[$];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.RR(1), .TIMEOUT(TO)) u_rr (
        .clk(clk), .rst_i(rst[0]),
        .m0_valid(m_valid[0][0]), .m0_addr(m_addr[0][0]), .m0_wdata(m_wdata[0][0]),
        .m0_wstrb(m_wstrb[0][0]), .m0_ready(m_ready[0][0]), .m0_rdata(m_rdata[0][0]),
        .m1_valid(m_valid[0][1]), .m1_addr(m_addr[0][1]), .m1_wdata(m_wdata[0][1]),
        .m1_wstrb(m_wstrb[0][1]), .m1_ready(m_ready[0][1]), .m1_rdata(m_rdata[0][1]),
        .s_valid(s_valid[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_wstrb(s_wstrb[0]),
        .s_ready(s_ready[0]), .s_rdata(s_rdata[0]),
        .grant(grant[0]), .busy(busy[0])
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        , .err(err[0])
`endif
    );

    mem_bus_arbiter #(.RR(0), .TIMEOUT(TO)) u_fp (
        .clk(clk), .rst_i(rst[1]),
        .m0_valid(m_valid[1][0]), .m0_addr(m_addr[1][0]), .m0_wdata(m_wdata[1][0]),
        .m0_wstrb(m_wstrb[1][0]), .m0_ready(m_ready[1][0]), .m0_rdata(m_rdata[1][0]),
        .m1_valid(m_valid[1][1]), .m1_addr(m_addr[1][1]), .m1_wdata(m_wdata[1][1]),
        .m1_wstrb(m_wstrb[1][1]), .m1_ready(m_ready[1][1]), .m1_rdata(m_rdata[1][1]),
        .s_valid(s_valid[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_wstrb(s_wstrb[1]),
        .s_ready(s_ready[1]), .s_rdata(s_rdata[1]),
        .grant(grant[1]), .busy(busy[1])
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        , .err(err[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a == 32'h0000_0010) ? 32'h1234_5678 : ({a[15:0], a[31:16]} ^ 32'h0F0F_0F0F);
    endfunction

    function automatic req_t mk_req(input logic [31:0] a, input logic [31:0] wd,
                                    input logic [3:0] ws, input int dly,
                                    input bit wiggle, input bit drop);
        req_t r;
        r.addr = a; r.wdata = wd; r.wstrb = ws; r.dly = dly; r.wiggle = wiggle; r.drop = drop;
        return r;
    endfunction

    function automatic exp_t mk_exp(input int m, input logic [31:0] a, input logic [31:0] wd,
                                    input logic [3:0] ws, input logic [31:0] rd,
                                    input int cycles, input bit e_err);
        exp_t e;
        e.m = m; e.addr = a; e.wdata = wd; e.wstrb = ws; e.rdata = rd;
        e.cycles = cycles; e.err = e_err;
        return e;
    endfunction

    // A request and its expected completion enter the scoreboard together.
    task automatic issue(input int d, input int m, input req_t r, input logic [31:0] rd,
                         input int cycles, input bit e_err);
        case (d * 2 + m)
            0: rq00.push_back(r);
            1: rq01.push_back(r);
            2: rq10.push_back(r);
            default: rq11.push_back(r);
        endcase
        if (d == 0) exp_q0.push_back(mk_exp(m, r.addr, r.wdata, r.wstrb, rd, cycles, e_err));
        else        exp_q1.push_back(mk_exp(m, r.addr, r.wdata, r.wstrb, rd, cycles, e_err));
    endtask

    function automatic int req_count(input int d, input int m);
        case (d * 2 + m)
            0: return rq00.size();
            1: return rq01.size();
            2: return rq10.size();
            default: return rq11.size();
        endcase
    endfunction

    function automatic req_t req_pop(input int d, input int m);
        case (d * 2 + m)
            0: return rq00.pop_front();
            1: return rq01.pop_front();
            2: return rq10.pop_front();
            default: return rq11.pop_front();
        endcase
    endfunction

    function automatic int exp_count(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic exp_t exp_front(input int d);
        return (d == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    function automatic exp_t exp_pop(input int d);
        if (d == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    // Master, slave and monitor state for both instances, owned by one process.
    req_t cur       [2][2];
    int   phase     [2][2];
    int   wcnt      [2][2];
    bit   done_seen [2][2];
    int   scnt      [2];
    int   gcyc      [2];
    bit   idle_chk  [2];
    int   poke_done [2];

    task automatic drive_step(input int d);
        if (s_ready[d]) begin
            s_ready[d] = 1'b0;
            scnt[d]    = 0;
        end else if (s_valid[d]) begin
            if (lat[d] >= 0 && scnt[d] == lat[d]) begin
                s_ready[d] = 1'b1;
                s_rdata[d] = slave_data(s_addr[d]);
            end else begin
                scnt[d]++;
            end
        end else begin
            scnt[d] = 0;
            if (poke_req[d] != poke_done[d]) begin
                s_ready[d] = 1'b1;
                s_rdata[d] = 32'hFFFF_FFFF;
                poke_done[d]++;
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (done_seen[d][m]) begin
                done_seen[d][m] = 1'b0;
                phase[d][m]     = 0;
                m_valid[d][m]   = 1'b0;
            end
            if (phase[d][m] == 0 && req_count(d, m) > 0) begin
                cur[d][m]   = req_pop(d, m);
                wcnt[d][m]  = cur[d][m].dly;
                phase[d][m] = 1;
            end
            if (phase[d][m] == 1) begin
                if (wcnt[d][m] == 0) begin
                    phase[d][m]   = 2;
                    m_valid[d][m] = 1'b1;
                    m_addr[d][m]  = cur[d][m].addr;
                    m_wdata[d][m] = cur[d][m].wdata;
                    m_wstrb[d][m] = cur[d][m].wstrb;
                end else begin
                    wcnt[d][m]--;
                end
            end else if (phase[d][m] == 2) begin
                if (cur[d][m].drop && grant[d][m]) begin
                    m_valid[d][m] = 1'b0;
                    phase[d][m]   = 3;
                end else if (cur[d][m].wiggle) begin
                    m_addr[d][m]  = grant[d][1-m] ? (cur[d][m].addr ^ $urandom) : cur[d][m].addr;
                    m_wdata[d][m] = grant[d][1-m] ? $urandom : cur[d][m].wdata;
                    m_wstrb[d][m] = grant[d][1-m] ? 4'(~cur[d][m].wstrb) : cur[d][m].wstrb;
                end
            end
        end
    endtask

    task automatic monitor_step(input int d);
        exp_t e;
        int   o;
        if (busy[d]) gcyc[d]++;
        else         gcyc[d] = 0;
        if (idle_chk[d]) begin
            check("idle_gap_grant", 32'(grant[d]), 32'h0);
            check("idle_gap_svalid", 32'(s_valid[d]), 32'h0);
`ifdef MEM_BUS_ARB_TIMEOUT_EN
            check("idle_gap_err", 32'(err[d]), 32'h0);
`endif
            idle_chk[d] = 1'b0;
        end
        if (m_ready[d][0] || m_ready[d][1]) begin
            for (int m = 0; m < 2; m++) if (m_ready[d][m]) done_seen[d][m] = 1'b1;
            if (exp_count(d) == 0) begin
                check("unexpected_ready", 32'h1, 32'h0);
            end else begin
                e = exp_pop(d);
                o = 1 - e.m;
                check("done_grant", 32'(grant[d]), 32'h1 << e.m);
                check("done_addr", s_addr[d], e.addr);
                check("done_wdata", s_wdata[d], e.wdata);
                check("done_wstrb", 32'(s_wstrb[d]), 32'(e.wstrb));
                check("done_ready", 32'(m_ready[d][e.m]), 32'h1);
                check("done_rdata", m_rdata[d][e.m], e.rdata);
                check("other_ready", 32'(m_ready[d][o]), 32'h0);
                check("other_rdata", m_rdata[d][o], 32'h0);
                check("done_latency", 32'(gcyc[d]), 32'(e.cycles));
`ifdef MEM_BUS_ARB_TIMEOUT_EN
                check("done_err", 32'(err[d]), 32'(e.err));
`endif
            end
            idle_chk[d] = 1'b1;
        end else if (s_valid[d] && exp_count(d) > 0) begin
            e = exp_front(d);
            check("hold_grant", 32'(grant[d]), 32'h1 << e.m);
            check("hold_addr", s_addr[d], e.addr);
            check("hold_wdata", s_wdata[d], e.wdata);
            check("hold_wstrb", 32'(s_wstrb[d]), 32'(e.wstrb));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            s_ready[d] = 1'b0; s_rdata[d] = '0;
            scnt[d] = 0; gcyc[d] = 0; idle_chk[d] = 1'b0; poke_done[d] = 0;
            for (int m = 0; m < 2; m++) begin
                m_valid[d][m] = 1'b0; m_addr[d][m] = '0; m_wdata[d][m] = '0; m_wstrb[d][m] = '0;
                phase[d][m] = 0; wcnt[d][m] = 0; done_seen[d][m] = 1'b0;
            end
        end
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) drive_step(d);
            @(negedge clk);
            for (int d = 0; d < 2; d++) monitor_step(d);
        end
    end

    task automatic reset_dut(input int d);
        @(negedge clk);
        rst[d] = 1'b1;
        @(negedge clk);
        rst[d] = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while (exp_count(d) > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            check("drain_timeout", 32'(exp_count(d)), 32'h0);
            if (d == 0) exp_q0.delete();
            else        exp_q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        rst[0] = 1'b1; rst[1] = 1'b1;
        lat[0] = 2;    lat[1] = 2;
        poke_req[0] = 0; poke_req[1] = 0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_svalid", 32'(s_valid[d]), 32'h0);
            check("rst_grant", 32'(grant[d]), 32'h0);
            check("rst_busy", 32'(busy[d]), 32'h0);
            check("rst_saddr", s_addr[d], 32'h0);
            check("rst_swdata", s_wdata[d], 32'h0);
            check("rst_swstrb", 32'(s_wstrb[d]), 32'h0);
        end
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Single CPU read with a two-cycle slave.
        issue(0, 0, mk_req(32'h0000_0010, 32'h0, 4'h0, 0, 0, 0), 32'h1234_5678, 3, 0);
        wait_drain(0);

        // Round-robin contention, three requests each.
        reset_dut(0);
        for (int i = 0; i < 3; i++) begin
            issue(0, 0, mk_req(32'h0000_0100 + 32'(i * 4), 32'h0, 4'h0, 0, 0, 0),
                  slave_data(32'h0000_0100 + 32'(i * 4)), 3, 0);
            issue(0, 1, mk_req(32'h0800_0200 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF, 0, 0, 0),
                  slave_data(32'h0800_0200 + 32'(i * 4)), 3, 0);
        end
        wait_drain(0);

        // Fixed priority: m0 keeps the bus until its valid drops.
        for (int i = 0; i < 4; i++)
            issue(1, 0, mk_req(32'h0000_1000 + 32'(i * 4), 32'h0, 4'h0, 0, 0, 0),
                  slave_data(32'h0000_1000 + 32'(i * 4)), 3, 0);
        for (int i = 0; i < 2; i++)
            issue(1, 1, mk_req(32'h0900_0000 + 32'(i * 4), 32'hCAFE_0000, 4'h1, 0, 0, 0),
                  slave_data(32'h0900_0000 + 32'(i * 4)), 3, 0);
        wait_drain(1);

        // Slave ready while idle must not complete anything.
        reset_dut(0);
        poke_req[0]++;
        repeat (2) begin
            @(negedge clk);
            check("poke_grant", 32'(grant[0]), 32'h0);
            check("poke_m0_ready", 32'(m_ready[0][0]), 32'h0);
            check("poke_m1_ready", 32'(m_ready[0][1]), 32'h0);
        end

        // m1 write held stable while m0 wiggles its request; m1 drops valid mid-grant.
        lat[0] = 4;
        issue(0, 1, mk_req(32'h1000_0000, 32'hA5A5_A5A5, 4'b0011, 0, 0, 1),
              slave_data(32'h1000_0000), 5, 0);
        issue(0, 0, mk_req(32'h2000_0040, 32'h0BAD_F00D, 4'hF, 2, 1, 0),
              slave_data(32'h2000_0040), 5, 0);
        wait_drain(0);

        // Reset during GNT1 abandons the transfer; held m1 request is granted again.
        reset_dut(0);
        lat[0] = 30;
        issue(0, 1, mk_req(32'h3000_0000, 32'h0, 4'h0, 0, 0, 0), slave_data(32'h3000_0000), 3, 0);
        n = 0;
        while (grant[0] !== 2'b10 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_gnt1", 32'(grant[0]), 32'h2);
        repeat (2) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        check("midrst_svalid", 32'(s_valid[0]), 32'h0);
        check("midrst_grant", 32'(grant[0]), 32'h0);
        check("midrst_busy", 32'(busy[0]), 32'h0);
        check("midrst_m1_ready", 32'(m_ready[0][1]), 32'h0);
        rst[0] = 1'b0;
        lat[0] = 2;
        wait_drain(0);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
        // Stuck slave: forced completion on the TO-th grant cycle.
        reset_dut(0);
        lat[0] = -1;
        issue(0, 0, mk_req(32'h4000_0000, 32'h0, 4'h0, 0, 0, 0), BUS_ERR_DATA, TO, 1);
        wait_drain(0);
        // s_ready on the timeout cycle completes normally.
        lat[0] = TO - 1;
        issue(0, 0, mk_req(32'h4000_0100, 32'h0, 4'h0, 0, 0, 0), slave_data(32'h4000_0100), TO, 0);
        wait_drain(0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter sharing the single on-chip memory/peripheral bus (picorv32 native valid/ready protocol) between the CPU core (m0) and a secondary requester such as a UART boot loader or DMA (m1).
- Grants one master at a time and registers the winning request onto the slave port.
- Routes the slave's ready/rdata back to the granted master only.
- Sits between picorv32 plus loader and the memory/UART decode logic.

Parameters:
- RR, 1: 1 = round-robin arbitration; 0 = fixed priority, m0 always wins.
- TIMEOUT, 255: cycles to wait for s_ready before forced completion (used only with the optional feature); 8-bit counter.

Ports:
- clk  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- m0_valid  in  1  CPU request; held until m0_ready
- m0_addr  in  32  CPU byte address
- m0_wdata  in  32  CPU write data
- m0_wstrb  in  4  CPU byte strobes; 0 = read
- m0_ready  out  1  one-cycle completion pulse to CPU
- m0_rdata  out  32  read data to CPU, valid with m0_ready
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as the m0_* ports, for master 1
- s_valid  out  1  request to slave
- s_addr  out  32  registered address
- s_wdata  out  32  registered write data
- s_wstrb  out  4  registered strobes
- s_ready  in  1  slave completion pulse
- s_rdata  in  32  slave read data
- grant  out  2  one-hot current owner; 00 when idle
- busy  out  1  high in GNT0/GNT1

Behaviour:
- Reset (rst_i high at a clk edge):
  - State goes to IDLE; s_valid, grant, busy = 0.
  - s_addr, s_wdata, s_wstrb = 0; last-grant pointer = m1 (so m0 wins first).
  - Reset mid-transaction abandons it with no ready to any master. A master still holding valid is re-arbitrated after reset.
- States:
  - IDLE: if any mX_valid, choose the winner, capture its addr/wdata/wstrb into the s_* registers, set s_valid = 1, go to GNTx.
  - GNT0/GNT1: wait for s_ready. On s_ready, go to IDLE, clear s_valid, update the last-grant pointer.
- Arbitration:
  - RR=1: both valid means the winner is the master not granted last; a single requester always wins.
  - RR=0: m0 wins whenever m0_valid is high.
- Latency:
  - Request sampled at edge N in IDLE; s_valid high from cycle N+1.
  - Slave s_ready at cycle N+k gives mX_ready in the same cycle N+k (combinational).
  - State is IDLE at N+k+1; the next grant has s_valid high at N+k+2. This gives one mandatory idle cycle between transactions.
- Return path:
  - mX_ready = s_ready & grant[X].
  - mX_rdata = s_rdata when grant[X], else 0.
  - The non-granted master never sees ready.
- Protocol rules:
  - s_* outputs are stable for the whole grant because they are registered.
  - A master dropping valid while granted has no effect; the transaction completes, and the ready pulse is still issued to that master.
  - s_ready while IDLE is ignored.
- No combinational path from mX_valid to s_valid.

Optional Feature:
- Macro: MEM_BUS_ARB_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on grant and increments each GNTx cycle without s_ready.
  - When it reaches TIMEOUT, the arbiter forces completion: mX_ready = 1 and mX_rdata = 32'hDEAD_BEEF for one cycle, s_valid drops, and the state returns to IDLE.
  - Output port err (1 bit) pulses with the forced ready; reset value 0.
  - An s_ready arriving in the same cycle as the timeout takes precedence: normal completion, no err.
- Undefined: no counter and no err port; the arbiter waits indefinitely for s_ready.

Decomposition:
- Shared package mem_bus_pkg:
  - State encoding constants ST_IDLE, ST_GNT0, ST_GNT1.
  - Constant BUS_ERR_DATA = 32'hDEAD_BEEF.
  - Bus width constants ADDR_W = 32, DATA_W = 32, STRB_W = 4.
- One natural sub-module, rr_pick2: combinational 2-way winner select from the valid bits, the last pointer and RR.
- Everything else stays in mem_bus_arbiter.

Test Plan:
- Reset, then m0 reads 0x0000_0010, slave readies 2 cycles after s_valid with rdata 0x1234_5678 -> m0_ready pulse, m0_rdata = 0x1234_5678, m1_ready stays 0, grant = 01 then 00.
- m0 and m1 valid in the same cycle after reset with RR=1, each with 3 back-to-back requests -> grant order m0, m1, m0, m1, m0, m1, with one idle cycle between transactions.
- RR=0, both continuously valid -> m0 granted every transaction; m1 granted only after m0_valid drops.
- m1 writes 0xA5A5_A5A5 with wstrb 0011 to 0x1000_0000 while m0 changes its addr mid-grant -> s_addr, s_wdata and s_wstrb hold m1's values until s_ready.
- rst_i asserted during GNT1 -> next cycle s_valid = 0, grant = 00, no m1_ready; m1 still valid gets regranted.
- With MEM_BUS_ARB_TIMEOUT_EN and TIMEOUT=8, slave never readies -> m0_ready and err pulse on the 8th GNT cycle, m0_rdata = 0xDEAD_BEEF.
